// File: rtl/action_decoder.sv
// action_decoder: converts the raw USB keycode into frame-synchronous
// move / jump / attack commands. Outputs update once per frame, on the
// cycle after a falling edge of the raw VGA vertical sync is seen, and
// hold for the rest of the frame.
// Optional feature macro: ACTION_DECODER_DASH_EN adds a dash action
// (KEY_DASH, DASH_COOLDOWN, dash_start) that works like attack.
module action_decoder #(
  parameter logic [7:0] KEY_LEFT        = 8'h04,
  parameter logic [7:0] KEY_RIGHT       = 8'h07,
  parameter logic [7:0] KEY_JUMP        = 8'h1A,
  parameter logic [7:0] KEY_ATTACK      = 8'h0D,
  parameter int         JUMP_MAX_FRAMES = 12,
`ifdef ACTION_DECODER_DASH_EN
  parameter logic [7:0] KEY_DASH        = 8'h0E,
  parameter int         DASH_COOLDOWN   = 30,
`endif
  parameter int         ATTACK_COOLDOWN = 20
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       vs,
  output logic       frame_tick,
  output logic [1:0] move_dir,
  output logic       jump_start,
  output logic       jump_active,
`ifdef ACTION_DECODER_DASH_EN
  output logic       dash_start,
`endif
  output logic       attack_start,
  output logic       attack_ready
);

  localparam int JCNT_W = $clog2(JUMP_MAX_FRAMES + 1);
  localparam int ACD_W  = $clog2(ATTACK_COOLDOWN + 1);
  localparam logic [JCNT_W-1:0] JMAX  = JCNT_W'(JUMP_MAX_FRAMES);
  localparam logic [JCNT_W-1:0] JONE  = JCNT_W'(1);
  localparam logic [ACD_W-1:0]  ACD   = ACD_W'(ATTACK_COOLDOWN);
  localparam logic [ACD_W-1:0]  A_ONE = ACD_W'(1);
`ifdef ACTION_DECODER_DASH_EN
  localparam int DCD_W = $clog2(DASH_COOLDOWN + 1);
  localparam logic [DCD_W-1:0]  DCD   = DCD_W'(DASH_COOLDOWN);
  localparam logic [DCD_W-1:0]  D_ONE = DCD_W'(1);
`endif

  typedef enum logic [1:0] {J_IDLE, J_RISE, J_LOCK} jstate_t;

  // vs history and sampled keycode
  logic       vs_q0, vs_q1;
  logic [7:0] key_q;
  logic       fall;

  // action state and registered outputs
  jstate_t           jstate_q, jstate_d;
  logic [JCNT_W-1:0] jcnt_q, jcnt_d;
  logic [ACD_W-1:0]  atk_cd_q, atk_cd_d;
  logic              prev_atk_q, prev_atk_d;
  logic              frame_tick_q, frame_tick_d;
  logic [1:0]        move_dir_q, move_dir_d;
  logic              jump_start_q, jump_start_d;
  logic              jump_active_q, jump_active_d;
  logic              attack_start_q, attack_start_d;
  logic              attack_ready_q, attack_ready_d;
`ifdef ACTION_DECODER_DASH_EN
  logic [DCD_W-1:0]  dash_cd_q, dash_cd_d;
  logic              prev_dash_q, prev_dash_d;
  logic              dash_start_q, dash_start_d;
  logic              is_dash, dash_hit;
`endif

  logic is_left, is_right, is_jump, is_atk, atk_hit;

  assign fall     = vs_q1 & ~vs_q0;
  assign is_left  = (key_q == KEY_LEFT);
  assign is_right = (key_q == KEY_RIGHT);
  assign is_jump  = (key_q == KEY_JUMP);
  assign is_atk   = (key_q == KEY_ATTACK);
  assign atk_hit  = is_atk & ~prev_atk_q;
`ifdef ACTION_DECODER_DASH_EN
  assign is_dash  = (key_q == KEY_DASH);
  assign dash_hit = is_dash & ~prev_dash_q;
`endif

  // Next-state for all frame-synchronous state; everything holds between ticks
  always_comb begin
    frame_tick_d   = fall;
    move_dir_d     = move_dir_q;
    jstate_d       = jstate_q;
    jcnt_d         = jcnt_q;
    jump_start_d   = jump_start_q;
    jump_active_d  = jump_active_q;
    atk_cd_d       = atk_cd_q;
    prev_atk_d     = prev_atk_q;
    attack_start_d = attack_start_q;
    attack_ready_d = attack_ready_q;
`ifdef ACTION_DECODER_DASH_EN
    dash_cd_d      = dash_cd_q;
    prev_dash_d    = prev_dash_q;
    dash_start_d   = dash_start_q;
`endif
    if (fall) begin
      if (is_left)       move_dir_d = 2'b01;
      else if (is_right) move_dir_d = 2'b10;
      else               move_dir_d = 2'b00;

      jump_start_d  = 1'b0;
      jump_active_d = 1'b0;
      case (jstate_q)
        J_IDLE: begin
          if (is_jump) begin
            jump_start_d  = 1'b1;
            jump_active_d = 1'b1;
            jcnt_d        = JONE;
            jstate_d      = J_RISE;
          end
        end
        J_RISE: begin
          if (is_jump && (jcnt_q < JMAX)) begin
            jcnt_d        = jcnt_q + JONE;
            jump_active_d = 1'b1;
          end else if (is_jump) begin
            jstate_d = J_LOCK;
          end else begin
            jcnt_d   = '0;
            jstate_d = J_IDLE;
          end
        end
        J_LOCK: begin
          // a held key must be released before another jump can start
          if (!is_jump) begin
            jcnt_d   = '0;
            jstate_d = J_IDLE;
          end
        end
        default: begin
          jcnt_d   = '0;
          jstate_d = J_IDLE;
        end
      endcase

      // presses during cooldown are dropped, never queued
      prev_atk_d = is_atk;
      if (atk_hit && (atk_cd_q == '0)) begin
        attack_start_d = 1'b1;
        atk_cd_d       = ACD;
      end else begin
        attack_start_d = 1'b0;
        if (atk_cd_q != '0) atk_cd_d = atk_cd_q - A_ONE;
      end
      attack_ready_d = (atk_cd_d == '0);

`ifdef ACTION_DECODER_DASH_EN
      prev_dash_d = is_dash;
      if (dash_hit && (dash_cd_q == '0)) begin
        dash_start_d = 1'b1;
        dash_cd_d    = DCD;
      end else begin
        dash_start_d = 1'b0;
        if (dash_cd_q != '0) dash_cd_d = dash_cd_q - D_ONE;
      end
`endif
    end
  end

  // State registers; vs history resets high so release cannot look like a fall
  always_ff @(posedge Clk) begin
    if (Reset) begin
      vs_q0          <= 1'b1;
      vs_q1          <= 1'b1;
      key_q          <= 8'h00;
      frame_tick_q   <= 1'b0;
      move_dir_q     <= 2'b00;
      jstate_q       <= J_IDLE;
      jcnt_q         <= '0;
      jump_start_q   <= 1'b0;
      jump_active_q  <= 1'b0;
      atk_cd_q       <= '0;
      prev_atk_q     <= 1'b0;
      attack_start_q <= 1'b0;
      attack_ready_q <= 1'b1;
`ifdef ACTION_DECODER_DASH_EN
      dash_cd_q      <= '0;
      prev_dash_q    <= 1'b0;
      dash_start_q   <= 1'b0;
`endif
    end else begin
      vs_q0          <= vs;
      vs_q1          <= vs_q0;
      key_q          <= keycode;
      frame_tick_q   <= frame_tick_d;
      move_dir_q     <= move_dir_d;
      jstate_q       <= jstate_d;
      jcnt_q         <= jcnt_d;
      jump_start_q   <= jump_start_d;
      jump_active_q  <= jump_active_d;
      atk_cd_q       <= atk_cd_d;
      prev_atk_q     <= prev_atk_d;
      attack_start_q <= attack_start_d;
      attack_ready_q <= attack_ready_d;
`ifdef ACTION_DECODER_DASH_EN
      dash_cd_q      <= dash_cd_d;
      prev_dash_q    <= prev_dash_d;
      dash_start_q   <= dash_start_d;
`endif
    end
  end

  assign frame_tick   = frame_tick_q;
  assign move_dir     = move_dir_q;
  assign jump_start   = jump_start_q;
  assign jump_active  = jump_active_q;
  assign attack_start = attack_start_q;
  assign attack_ready = attack_ready_q;
`ifdef ACTION_DECODER_DASH_EN
  assign dash_start   = dash_start_q;
`endif

endmodule

// File: tb/tb_action_decoder.sv
// tb_action_decoder: frame-level bench for action_decoder. A behavioural
// model tracks, per frame, how long the jump key has been held and how many
// frames have passed since the last attack/dash. Build with
// ACTION_DECODER_DASH_EN defined to cover the dash action as well.
module tb_action_decoder;

  localparam int JMAX = 12;
  localparam int ACD  = 20;
  localparam int DCD  = 30;
  localparam int SAT  = 1000;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] keycode;
  logic       vs;
  logic       frame_tick;
  logic [1:0] move_dir;
  logic       jump_start, jump_active, attack_start, attack_ready;
`ifdef ACTION_DECODER_DASH_EN
  logic       dash_start;
`endif

  action_decoder dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .keycode      (keycode),
    .vs           (vs),
    .frame_tick   (frame_tick),
    .move_dir     (move_dir),
    .jump_start   (jump_start),
    .jump_active  (jump_active),
`ifdef ACTION_DECODER_DASH_EN
    .dash_start   (dash_start),
`endif
    .attack_start (attack_start),
    .attack_ready (attack_ready)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  // model state
  int   held;
  bit   prev_atk, prev_dash;
  int   since_atk, since_dash;
  logic [1:0] e_move;
  bit   e_js, e_ja, e_as, e_ar, e_ds;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    held = 0; prev_atk = 0; prev_dash = 0;
    since_atk = SAT; since_dash = SAT;
    e_move = 2'b00; e_js = 0; e_ja = 0; e_as = 0; e_ar = 1; e_ds = 0;
  endtask

  task automatic model_tick(input logic [7:0] k);
    e_move = (k == 8'h04) ? 2'b01 : (k == 8'h07) ? 2'b10 : 2'b00;
    held   = (k == 8'h1A) ? ((held < SAT) ? held + 1 : held) : 0;
    e_js   = (held == 1);
    e_ja   = (held >= 1) && (held <= JMAX);
    if (since_atk < SAT) since_atk++;
    if (k == 8'h0D && !prev_atk && since_atk > ACD) begin e_as = 1; since_atk = 0; end
    else e_as = 0;
    prev_atk = (k == 8'h0D);
    e_ar = (since_atk >= ACD);
`ifdef ACTION_DECODER_DASH_EN
    if (since_dash < SAT) since_dash++;
    if (k == 8'h0E && !prev_dash && since_dash > DCD) begin e_ds = 1; since_dash = 0; end
    else e_ds = 0;
    prev_dash = (k == 8'h0E);
`endif
  endtask

  task automatic check_outs();
    chk("move_dir", move_dir, e_move);
    chk("jump_start", jump_start, e_js);
    chk("jump_active", jump_active, e_ja);
    chk("attack_start", attack_start, e_as);
    chk("attack_ready", attack_ready, e_ar);
`ifdef ACTION_DECODER_DASH_EN
    chk("dash_start", dash_start, e_ds);
`endif
  endtask

  // One frame: idle with vs high (outputs must hold, no tick), then a vs low pulse.
  task automatic run_frame(input logic [7:0] k);
    keycode = k;
    repeat (3) begin
      @(posedge Clk); #1;
      chk("no_tick_idle", frame_tick, 0);
      check_outs();
    end
    vs = 1'b0;
    @(posedge Clk); #1;
    chk("tick_early", frame_tick, 0);
    @(posedge Clk); #1;
    chk("tick_latency", frame_tick, 1);
    model_tick(k);
    check_outs();
    @(posedge Clk); #1;
    chk("tick_single", frame_tick, 0);
    check_outs();
    vs = 1'b1;
  endtask

  logic [7:0] pool [6] = '{8'h00, 8'h04, 8'h07, 8'h1A, 8'h0D, 8'h0E};

  initial begin
    logic [7:0] k;
    Reset = 1'b1; vs = 1'b1; keycode = 8'h07;
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_tick", frame_tick, 0);
    check_outs();
    Reset = 1'b0;

    // move right then left, other keys clear it
    run_frame(8'h07);
    run_frame(8'h04);
    run_frame(8'h55);

    // jump held 20 frames, released, re-pressed
    for (int i = 0; i < 20; i++) run_frame(8'h1A);
    run_frame(8'h00);
    run_frame(8'h1A);
    run_frame(8'h00);

    // short jump
    for (int i = 0; i < 3; i++) run_frame(8'h1A);
    run_frame(8'h00);
    run_frame(8'h00);

    // attack taps inside and after cooldown, then a long hold
    run_frame(8'h0D);
    for (int i = 0; i < 4; i++) run_frame(8'h00);
    run_frame(8'h0D);
    for (int i = 0; i < 20; i++) run_frame(8'h00);
    run_frame(8'h0D);
    for (int i = 0; i < 25; i++) run_frame(8'h00);
    for (int i = 0; i < 40; i++) run_frame(8'h0D);
    run_frame(8'h00);

    // dash taps (plain no-key frames when dash is not built)
    run_frame(8'h0E);
    run_frame(8'h00);
    run_frame(8'h0E);
    for (int i = 0; i < 31; i++) run_frame(8'h00);
    run_frame(8'h0E);

    // reset in the middle of a jump
    for (int i = 0; i < 5; i++) run_frame(8'h1A);
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    model_reset();
    chk("rst_mid_tick", frame_tick, 0);
    check_outs();
    run_frame(8'h1A);

    // random key sequences, with repeats so holds happen
    k = 8'h00;
    for (int i = 0; i < 250; i++) begin
      int sel;
      sel = $urandom_range(0, 8);
      if (sel < 6) k = pool[sel];
      else if (sel == 6) k = 8'($urandom);
      run_frame(k);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
